audio_sample_sequencer: RTL and testbench
=========================================

// Module: audio_sample_sequencer
// PURPOSE
//  Sequences one audio sample per period: ADC start, capture, gain, DAC load.
//  Sits between the parallel ADC and DAC interfaces of the sound processor.
//  Divides sysclk into a sample tick and removes the ADC offset.
//  Applies a selectable power-of-2 gain with saturation, so overdrive clips instead of wrapping.
//  Hands the result to the DAC with a valid/ready handshake.
// PARAMETERS
//  CLK_DIV      1000    sample period in sysclk cycles (>=8)
//  ADC_OFFSET   10'h181 ADC code for zero signal
//  DAC_OFFSET   10'h200 DAC code for zero signal
//  ADC_TIMEOUT  64      max cycles to wait for adc_done
// PORTS
//  sysclk    in   1   system clock, all logic on rising edge
//  rst       in   1   asynchronous active-high reset
//  enable    in   1   1 = generate sample ticks
//  gain_sel  in   2   gain = 2**gain_sel (x1..x8)
//  ovr_clr   in   1   clears sticky overrun
//  adc_start out  1   one-cycle conversion request
//  adc_done  in   1   conversion complete, adc_data valid this cycle
//  adc_data  in  10   raw ADC code
//  dac_data  out 10   DAC code, registered
//  dac_load  out  1   dac_data valid; held until accepted
//  dac_ready in   1   DAC accepts when dac_load & dac_ready at a clock edge
//  clip      out  1   one-cycle pulse: the current sample saturated
//  timeout   out  1   one-cycle pulse: adc_done not seen in ADC_TIMEOUT cycles
//  overrun   out  1   sticky: tick arrived while not IDLE
//  busy      out  1   state != IDLE
// BEHAVIOUR
//  Reset values: all 1-bit outputs 0, dac_data = DAC_OFFSET, state IDLE, counters 0.
//  Tick counter
//   - While enable=1: counts 0..CLK_DIV-1 and wraps; tick = (cnt==CLK_DIV-1).
//   - While enable=0: counter held at 0 and no ticks.
//  FSM states: IDLE, CONVERT, WAIT_ADC, PROCESS, DAC_LOAD.
//   - IDLE: tick -> CONVERT.
//   - CONVERT: adc_start=1 for exactly this cycle; latch gain_sel; -> WAIT_ADC with wait cnt=0.
//   - WAIT_ADC:
//       adc_done=1 -> capture adc_data, -> PROCESS.
//       else wait cnt==ADC_TIMEOUT-1 -> pulse timeout, -> IDLE (no DAC load).
//   - PROCESS (1 cycle):
//       x = adc_data - ADC_OFFSET, mod 2^10, as signed 10-bit.
//       y = sext13(x) <<< gain, saturated to [-512,+511]; clip pulses if saturated.
//       -> DAC_LOAD.
//   - DAC_LOAD: dac_data = y[9:0] + DAC_OFFSET (mod 2^10), dac_load=1;
//       stays until dac_ready=1 at an edge, then dac_load drops and -> IDLE.
//  Latency: adc_done sampled at edge N -> dac_load=1 and dac_data valid after edge N+2.
//  dac_data holds its last value between loads; dac_data must not change while dac_load=1.
//  Tick while state!=IDLE: tick dropped, overrun set.
//  Simultaneous overrun set and ovr_clr: set wins.
//  enable falling mid-sample: current sample completes normally.
//  adc_done outside WAIT_ADC: ignored.
//  Reset mid-operation: immediate return to reset values; pending sample discarded.
// TESTING
//  adc_data=0x191, gain_sel=2, dac_ready=1 -> dac_data=0x240, clip=0, dac_load 1 cycle.
//  adc_data=0x281, gain_sel=2 (x=256 -> 1024) -> dac_data=0x3FF, clip pulse.
//  adc_data=0x081, gain_sel=1 -> dac_data=0x000, clip=0; same input at gain_sel=3 -> dac_data=0x000, clip=1.
//  adc_done never asserted -> timeout pulse 64 cycles after adc_start, no dac_load, next tick restarts.
//  dac_ready held 0 across next tick -> overrun=1, dac_data stable; then ovr_clr -> overrun=0.
//  Assert rst during WAIT_ADC -> outputs at reset values same cycle, dac_data=0x200, busy=0.

Source files
------------

// File: rtl/audio_sample_sequencer.sv
// Audio sample sequencer: divides sysclk into sample ticks, then runs one
// ADC conversion, offset removal, saturating power-of-2 gain, and DAC hand-off per tick.
module audio_sample_sequencer #(
  parameter int unsigned CLK_DIV     = 1000,
  parameter logic [9:0]  ADC_OFFSET  = 10'h181,
  parameter logic [9:0]  DAC_OFFSET  = 10'h200,
  parameter int unsigned ADC_TIMEOUT = 64
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] gain_sel,
  input  logic       ovr_clr,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [9:0] adc_data,
  output logic [9:0] dac_data,
  output logic       dac_load,
  input  logic       dac_ready,
  output logic       clip,
  output logic       timeout,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_WAIT_ADC,
    S_PROCESS,
    S_DAC_LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]  gain_q, gain_d;
  logic [9:0]  raw_q, raw_d;
  logic [9:0]  y_q, y_d;
  logic [9:0]  dac_data_q, dac_data_d;
  logic        dac_load_q, dac_load_d;
  logic        overrun_q, overrun_d;

  logic        tick;
  logic [9:0]  diff;
  logic signed [12:0] shifted;
  logic        sat_hi, sat_lo;
  logic [9:0]  y_sat;
  logic        adc_start_c, timeout_c, clip_c;

  assign tick = enable && (cnt_q == CW'(CLK_DIV - 1));

  // Offset removal wraps mod 2^10 and is reinterpreted as signed before the shift.
  always_comb begin
    diff    = raw_q - ADC_OFFSET;
    shifted = $signed({{3{diff[9]}}, diff}) <<< gain_q;
    sat_hi  = shifted > 13'sd511;
    sat_lo  = shifted < -13'sd512;
    if (sat_hi) begin
      y_sat = 10'h1FF;
    end else if (sat_lo) begin
      y_sat = 10'h200;
    end else begin
      y_sat = shifted[9:0];
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    wait_d      = wait_q;
    gain_d      = gain_q;
    raw_d       = raw_q;
    y_d         = y_q;
    dac_data_d  = dac_data_q;
    dac_load_d  = dac_load_q;
    overrun_d   = overrun_q;
    adc_start_c = 1'b0;
    timeout_c   = 1'b0;
    clip_c      = 1'b0;

    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Set has priority over clear so a tick lost in the same cycle is never hidden.
    if (ovr_clr) overrun_d = 1'b0;
    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        adc_start_c = 1'b1;
        gain_d      = gain_sel;
        wait_d      = '0;
        state_d     = S_WAIT_ADC;
      end
      S_WAIT_ADC: begin
        if (adc_done) begin
          raw_d   = adc_data;
          state_d = S_PROCESS;
        end else if (wait_q == WW'(ADC_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_PROCESS: begin
        clip_c  = sat_hi || sat_lo;
        y_d     = y_sat;
        state_d = S_DAC_LOAD;
      end
      S_DAC_LOAD: begin
        // First cycle loads the output register; dac_data is frozen after that.
        if (!dac_load_q) begin
          dac_data_d = y_q + DAC_OFFSET;
          dac_load_d = 1'b1;
        end else if (dac_ready) begin
          dac_load_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      gain_q     <= '0;
      raw_q      <= '0;
      y_q        <= '0;
      dac_data_q <= DAC_OFFSET;
      dac_load_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      gain_q     <= gain_d;
      raw_q      <= raw_d;
      y_q        <= y_d;
      dac_data_q <= dac_data_d;
      dac_load_q <= dac_load_d;
      overrun_q  <= overrun_d;
    end
  end

  assign adc_start = adc_start_c;
  assign timeout   = timeout_c;
  assign clip      = clip_c;
  assign dac_data  = dac_data_q;
  assign dac_load  = dac_load_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Randomized bench for audio_sample_sequencer: a tick-schedule model predicts
// starts and overrun, and an arithmetic model predicts gain, clip and DAC codes.
module tb_audio_sample_sequencer;

  localparam int DIV = 80;
  localparam int TO  = 64;
  localparam int NTX = 40;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] gain_sel = 2'd0;
  logic       ovr_clr = 1'b0;
  logic       adc_start;
  logic       adc_done = 1'b0;
  logic [9:0] adc_data = 10'd0;
  logic [9:0] dac_data;
  logic       dac_load;
  logic       dac_ready = 1'b0;
  logic       clip;
  logic       timeout;
  logic       overrun;
  logic       busy;

  audio_sample_sequencer #(
    .CLK_DIV    (DIV),
    .ADC_OFFSET (10'h181),
    .DAC_OFFSET (10'h200),
    .ADC_TIMEOUT(TO)
  ) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .enable   (enable),
    .gain_sel (gain_sel),
    .ovr_clr  (ovr_clr),
    .adc_start(adc_start),
    .adc_done (adc_done),
    .adc_data (adc_data),
    .dac_data (dac_data),
    .dac_load (dac_load),
    .dac_ready(dac_ready),
    .clip     (clip),
    .timeout  (timeout),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0 = 0;
  int s_cyc = 0;
  bit in_flight = 1'b0;
  bit tick_now = 1'b0;
  bit exp_ov = 1'b0;
  int last_dac = 'h200;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, act, exp);
    end
  endtask

  // Ticks fall every DIV enabled edges after enable was raised; a tick while a
  // sample is in flight is dropped and flags overrun, otherwise it starts a sample.
  task automatic step();
    bit en_s, clr_s, st;
    en_s = enable;
    clr_s = ovr_clr;
    @(posedge sysclk);
    #1;
    cyc++;
    tick_now = en_s && (cyc > c0) && (((cyc - c0) % DIV) == 0);
    if (tick_now && in_flight) exp_ov = 1'b1;
    else if (clr_s) exp_ov = 1'b0;
    st = tick_now && !in_flight;
    if (st) begin
      in_flight = 1'b1;
      s_cyc = cyc;
    end
    check_eq("adc_start", adc_start, st);
    check_eq("overrun", overrun, exp_ov);
  endtask

  function automatic void model(input int raw, input int g, output int dac, output bit clp);
    int x, y;
    x = (raw - 'h181) & 1023;
    if (x >= 512) x -= 1024;
    y = x * (1 << g);
    clp = 1'b0;
    if (y > 511) begin y = 511; clp = 1'b1; end
    else if (y < -512) begin y = -512; clp = 1'b1; end
    dac = ((y & 1023) + 'h200) & 1023;
  endfunction

  int  dir_raw[4] = '{'h191, 'h281, 'h081, 'h081};
  int  dir_g[4]   = '{2, 2, 1, 3};
  int  k, m, rr, raw, g, exp_dac, s;
  bit  exp_clip, drop_en, to, long_wait;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_eq("rst_dac_data", dac_data, 'h200);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dac_load", dac_load, 0);
    check_eq("rst_outputs", {adc_start, clip, timeout, overrun}, 0);
    @(posedge sysclk);
    #1;
    rst = 1'b0;
    enable = 1'b1;
    cyc = 0;
    c0 = 0;

    for (int t = 0; t < NTX; t++) begin
      k = 0;
      while (!in_flight && k < 2 * DIV + 4) begin step(); k++; end
      check_eq("start_seen", in_flight, 1);
      if (!in_flight) continue;
      s = s_cyc;
      check_eq("busy_start", busy, 1);
      g = (t < 4) ? dir_g[t] : int'($urandom_range(0, 3));
      gain_sel = g[1:0];
      if ($urandom_range(0, 3) == 0) begin
        adc_done = 1'b1;
        adc_data = 10'($urandom);
      end
      drop_en = (t >= 4) && ($urandom_range(0, 7) == 0);
      if (drop_en) enable = 1'b0;
      step();
      adc_done = 1'b0;
      gain_sel = 2'($urandom);

      if (t == NTX / 2) begin
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_dac_data", dac_data, 'h200);
        check_eq("rstmid_outputs", {adc_start, dac_load, clip, timeout, overrun}, 0);
        @(posedge sysclk);
        #1;
        cyc++;
        check_eq("rstmid_hold", {busy, dac_load}, 0);
        rst = 1'b0;
        enable = 1'b1;
        c0 = cyc;
        in_flight = 1'b0;
        exp_ov = 1'b0;
        last_dac = 'h200;
        continue;
      end

      to = (t == 4) || ((t > 4) && ($urandom_range(0, 5) == 0));
      if (to) begin
        while (cyc < s + TO) begin
          check_eq("no_timeout", timeout, 0);
          step();
        end
        check_eq("timeout", timeout, 1);
        check_eq("to_no_load", dac_load, 0);
        step();
        check_eq("timeout_end", timeout, 0);
        check_eq("to_busy", busy, 0);
        check_eq("to_dac_hold", dac_data, last_dac);
        $display("tx %0d: timeout start=%0d", t, s);
      end else begin
        m = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(1, 6));
        while (cyc < s + m) step();
        raw = (t < 4) ? dir_raw[t] : int'($urandom_range(0, 1023));
        adc_done = 1'b1;
        adc_data = raw[9:0];
        if (m == TO) begin
          #1;
          check_eq("done_beats_timeout", timeout, 0);
        end
        step();
        adc_done = 1'b0;
        adc_data = 10'($urandom);
        model(raw, g, exp_dac, exp_clip);
        check_eq("clip", clip, exp_clip);
        step();
        check_eq("clip_pulse_end", clip, 0);
        check_eq("load_latency", dac_load, 0);
        long_wait = (t >= 4) && ($urandom_range(0, 7) == 0);
        rr = long_wait ? DIV + 3 : int'($urandom_range(0, 3));
        if (rr == 0 && $urandom_range(0, 1) == 1) dac_ready = 1'b1;
        if (long_wait) ovr_clr = 1'b1;
        step();
        check_eq("dac_load", dac_load, 1);
        check_eq("dac_data", dac_data, exp_dac);
        if (tick_now) ovr_clr = 1'b0;
        for (int i = 0; i < rr; i++) begin
          step();
          check_eq("load_held", dac_load, 1);
          check_eq("data_stable", dac_data, exp_dac);
          if (tick_now) ovr_clr = 1'b0;
        end
        dac_ready = 1'b1;
        step();
        dac_ready = 1'b0;
        ovr_clr = 1'b0;
        check_eq("load_drop", dac_load, 0);
        check_eq("busy_end", busy, 0);
        check_eq("dac_hold", dac_data, exp_dac);
        last_dac = exp_dac;
        $display("tx %0d: raw=%03h gain=%0d dac=%03h clip=%0d wait=%0d", t, raw, g, dac_data, exp_clip, rr);
      end
      in_flight = 1'b0;

      if ($urandom_range(0, 2) == 0) begin
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
      end
      if (drop_en) begin
        repeat (DIV + 8) step();
        enable = 1'b1;
        c0 = cyc;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
